// File: rtl/key_event_ctrl.sv
// Classifies debounced press/release pulses of one key into single click, double click,
// long press and long-press auto-repeat events, each a registered single-cycle pulse.
module key_event_ctrl #(
    parameter int unsigned LONG_T = 50_000_000,
    parameter int unsigned DCLK_T = 15_000_000,
    parameter int unsigned REP_T  = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic press,
    // Key-up edge pulse; "release" itself is a reserved word in SystemVerilog.
    input  logic rel,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_repeat,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    localparam logic [31:0] LONG_LAST = 32'(LONG_T - 1);
    localparam logic [31:0] DCLK_LAST = 32'(DCLK_T - 1);
    localparam logic [31:0] REP_LAST  = 32'(REP_T - 1);

    state_t      state;
    logic [31:0] cnt;
    logic        press_ok;
    logic        rel_ok;

    // A press and a release in the same cycle cancel each other out.
    assign press_ok = press & ~rel;
    assign rel_ok   = rel & ~press;

    // NOTE: sequential state uses non-blocking assignments only; the event pulses
    // default to 0 at the top so each one lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            long_repeat  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            long_repeat  <= 1'b0;

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (press_ok) begin
                            state <= PRESS1;
                            busy  <= 1'b1;
                        end
                    end

                    PRESS1: begin
                        if (rel_ok) begin
                            state <= WAIT2;
                            cnt   <= '0;
                        end else if (cnt == LONG_LAST) begin
                            state      <= LONG;
                            cnt        <= '0;
                            long_press <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end

                    // Stray releases here are ignored; only a press or the timeout matters.
                    WAIT2: begin
                        if (press_ok) begin
                            state <= PRESS2;
                            cnt   <= '0;
                        end else if (cnt == DCLK_LAST) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            single_click <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end

                    PRESS2: begin
                        cnt <= '0;
                        if (rel_ok) begin
                            state        <= IDLE;
                            double_click <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end

                    LONG: begin
                        if (rel_ok) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == REP_LAST) begin
                            cnt         <= '0;
                            long_repeat <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: table of gesture scenarios checked cycle by cycle,
// plus hand-written reset sequences.
module tb_key_event_ctrl;

    localparam int LONG_T = 20;
    localparam int DCLK_T = 8;
    localparam int REP_T  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic press = 1'b0;
    logic rel = 1'b0;
    logic single_click, double_click, long_press, long_repeat, busy;

    int errors = 0;
    int checks = 0;

    key_event_ctrl #(
        .LONG_T(LONG_T),
        .DCLK_T(DCLK_T),
        .REP_T (REP_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .press       (press),
        .rel         (rel),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .long_repeat (long_repeat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle numbers are relative to the first stimulus cycle; -1 means "never".
    typedef struct {
        int n;
        int p0, p1, r0, r1;
        int en_off;
        int e_single, e_double, e_long;
        int e_rep0, e_rep1, e_rep2;
        int busy_on, busy_off;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [4:0] outs();
        return {single_click, double_click, long_press, long_repeat, busy};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {sc,dc,lp,lr,busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        press = 1'b0;
        rel   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //         n  p0 p1  r0  r1 enoff  sc  dc  lp  r0  r1  r2 bon boff
        tbl[0] = '{20, 0, -1,  3, -1, -1, 12, -1, -1, -1, -1, -1, 1, 12}; // single click
        tbl[1] = '{20, 0,  7,  3,  9, -1, -1, 10, -1, -1, -1, -1, 1, 10}; // double click
        tbl[2] = '{45, 0, -1, 37, -1, -1, -1, -1, 21, 26, 31, 36, 1, 38}; // long + repeat
        tbl[3] = '{35, 0, -1, 20, -1, -1, 29, -1, -1, -1, -1, -1, 1, 29}; // release on LONG_T-1
        tbl[4] = '{20, 0, 11,  3, 12, -1, -1, 13, -1, -1, -1, -1, 1, 13}; // press on timeout
        tbl[5] = '{40, 0, -1, -1, -1, 10, -1, -1, -1, -1, -1, -1, 1, 11}; // en dropped
        tbl[6] = '{15, 0, -1,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1}; // simultaneous
        tbl[7] = '{20, 0, -1,  3,  5, -1, 12, -1, -1, -1, -1, -1, 1, 12}; // stray release
        tbl[8] = '{30, 0, -1, 25, -1, -1, -1, -1, 21, -1, -1, -1, 1, 26}; // release beats repeat

        // Reset held: outputs stay low even with a press pulse presented.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        press = 1'b1;
        @(negedge clk);
        check("reset_held", outs(), 5'b00000);
        press = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_released", outs(), 5'b00000);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int c = 0; c < tbl[v].n; c++) begin
                logic [4:0] exp;
                // Still inside negedge of cycle c: outputs reflect cycle c.
                exp[4] = (c == tbl[v].e_single);
                exp[3] = (c == tbl[v].e_double);
                exp[2] = (c == tbl[v].e_long);
                exp[1] = (c == tbl[v].e_rep0) || (c == tbl[v].e_rep1) || (c == tbl[v].e_rep2);
                exp[0] = (tbl[v].busy_on >= 0) && (c >= tbl[v].busy_on) && (c < tbl[v].busy_off);
                check($sformatf("vec%0d_cycle%0d", v, c), outs(), exp);
                press = (c == tbl[v].p0) || (c == tbl[v].p1);
                rel   = (c == tbl[v].r0) || (c == tbl[v].r1);
                en    = !((tbl[v].en_off >= 0) && (c >= tbl[v].en_off));
                @(negedge clk);
            end
            press = 1'b0;
            rel   = 1'b0;
            en    = 1'b1;
        end

        // Async reset in the middle of a long hold: immediate clear, no later long_press.
        do_reset();
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        repeat (14) @(negedge clk);
        check("hold_busy_c15", outs(), 5'b00001);
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_hold", outs(), 5'b00000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("after_reset_cycle%0d", c), outs(), 5'b00000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
